assert_ctrl_responder: RTL

Synthesizable responder for assertion-control commands: it takes the lock, unlock, on, off, kill and vacuous-off commands issued over a valid/ready channel and keeps per-slot enable, lock and vacuous-pass state for up to NUM_SLOTS checker instances. It also holds three global violation-report enables for unique, unique0 and priority decisions. It sits between the debug/control initiator and the on-chip checker array. Each checker reads its slot_en, slot_vac_en and slot_kill bits.

---
 rtl/assert_ctrl_responder.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/assert_ctrl_responder.sv
// ---------------------------------------------------------------------------
// assert_ctrl_responder
//
// Responder for assertion-control commands. It accepts lock / unlock / on /
// off / kill / vacuous-off / vacuous-on commands over a valid/ready channel
// and keeps the per-slot enable, vacuous-pass enable and lock state for up to
// NUM_SLOTS checker instances. It also keeps the three global violation-report
// enables for unique, unique0 and priority decisions. Each accepted command
// produces one response that gives the number of slots affected and flags
// illegal control codes.
//
// Parameters
//   NUM_SLOTS   number of checker slots (1..32)
//   SLOT_ATYPE  packed NUM_SLOTS x 8 assertion-type bits per slot
//               (bit0 concurrent, bit1 simple immediate, bits2-3 deferred,
//               bit4 expect, bits5-7 zero)
//   SLOT_DTYPE  packed NUM_SLOTS x 3 directive bits per slot
//               (bit0 assert, bit1 cover, bit2 assume)
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   cmd_valid     command valid
//   cmd_ready     responder idle and able to take a command
//   cmd_ctrl      1 LOCK, 2 UNLOCK, 3 ON, 4 OFF, 5 KILL, 11 VACUOUSOFF,
//                 12 VACUOUSON; any other value is illegal
//   cmd_atype     assertion-type mask; bits 7:5 select priority/unique0/unique
//   cmd_dtype     directive-type mask
//   cmd_sel       slot select, all-zero selects every slot
//   slot_en       per-slot checker enable
//   slot_vac_en   per-slot vacuous-pass action enable
//   slot_kill     per-slot one-cycle kill pulse
//   viol_en       {priority, unique0, unique} violation-report enables
//   rsp_valid     response valid, held until rsp_ready
//   rsp_ready     response accepted
//   rsp_hits      number of slots changed or pulsed by the command
//   rsp_err       illegal control code
// ---------------------------------------------------------------------------
module assert_ctrl_responder #(
  parameter int                     NUM_SLOTS  = 8,
  parameter logic [8*NUM_SLOTS-1:0] SLOT_ATYPE = {NUM_SLOTS{8'h01}},
  parameter logic [3*NUM_SLOTS-1:0] SLOT_DTYPE = {NUM_SLOTS{3'b001}},
  localparam int                    HW         = $clog2(NUM_SLOTS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd_ctrl,
  input  logic [7:0]           cmd_atype,
  input  logic [2:0]           cmd_dtype,
  input  logic [NUM_SLOTS-1:0] cmd_sel,
  output logic [NUM_SLOTS-1:0] slot_en,
  output logic [NUM_SLOTS-1:0] slot_vac_en,
  output logic [NUM_SLOTS-1:0] slot_kill,
  output logic [2:0]           viol_en,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [HW-1:0]        rsp_hits,
  output logic                 rsp_err
);

  localparam logic [3:0] CTRL_LOCK   = 4'd1;
  localparam logic [3:0] CTRL_UNLOCK = 4'd2;
  localparam logic [3:0] CTRL_ON     = 4'd3;
  localparam logic [3:0] CTRL_OFF    = 4'd4;
  localparam logic [3:0] CTRL_KILL   = 4'd5;
  localparam logic [3:0] CTRL_VACOFF = 4'd11;
  localparam logic [3:0] CTRL_VACON  = 4'd12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state;

  // Command fields captured at the handshake; only meaningful in APPLY.
  logic [3:0]           ctrl_p0;
  logic [7:0]           atype_p0;
  logic [2:0]           dtype_p0;
  logic [NUM_SLOTS-1:0] sel_p0;

  logic [NUM_SLOTS-1:0] lock;

  // Next-state values computed from the captured command in APPLY.
  logic [NUM_SLOTS-1:0] match;
  logic [NUM_SLOTS-1:0] eff;
  logic [NUM_SLOTS-1:0] lock_nxt;
  logic [NUM_SLOTS-1:0] en_nxt;
  logic [NUM_SLOTS-1:0] vac_nxt;
  logic [NUM_SLOTS-1:0] kill_nxt;
  logic [2:0]           viol_nxt;
  logic [HW-1:0]        hits_nxt;
  logic                 err_nxt;

  function automatic logic [HW-1:0] popcount(input logic [NUM_SLOTS-1:0] v);
    logic [HW-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      c = c + HW'(v[i]);
    end
    return c;
  endfunction

  // Capture stage: command fields carry no reset, they are only consumed
  // after a handshake has loaded them.
  always_ff @(posedge clk) begin
    if (state == IDLE && cmd_valid) begin
      ctrl_p0  <= cmd_ctrl;
      atype_p0 <= cmd_atype;
      dtype_p0 <= cmd_dtype;
      sel_p0   <= cmd_sel;
    end
  end

  // Apply stage: slot matching and per-command effect.
  always_comb begin
    match    = '0;
    lock_nxt = lock;
    en_nxt   = slot_en;
    vac_nxt  = slot_vac_en;
    kill_nxt = '0;
    viol_nxt = viol_en;
    hits_nxt = '0;
    err_nxt  = 1'b0;

    for (int i = 0; i < NUM_SLOTS; i++) begin
      match[i] = (|(SLOT_ATYPE[8*i +: 5] & atype_p0[4:0])) &
                 (|(SLOT_DTYPE[3*i +: 3] & dtype_p0)) &
                 ((sel_p0 == '0) | sel_p0[i]);
    end
    // Lock as it stood before this command, so a LOCK never shields itself
    // and an UNLOCK does not open the slot to its own command.
    eff = match & ~lock;

    case (ctrl_p0)
      CTRL_LOCK: begin
        lock_nxt = lock | match;
        hits_nxt = popcount(match);
      end
      CTRL_UNLOCK: begin
        lock_nxt = lock & ~match;
        hits_nxt = popcount(match);
      end
      CTRL_ON: begin
        en_nxt   = slot_en | eff;
        viol_nxt = viol_en | atype_p0[7:5];
        hits_nxt = popcount(eff);
      end
      CTRL_OFF: begin
        en_nxt   = slot_en & ~eff;
        viol_nxt = viol_en & ~atype_p0[7:5];
        hits_nxt = popcount(eff);
      end
      CTRL_KILL: begin
        kill_nxt = eff;
        hits_nxt = popcount(eff);
      end
      CTRL_VACOFF: begin
        vac_nxt  = slot_vac_en & ~eff;
        hits_nxt = popcount(eff);
      end
      CTRL_VACON: begin
        vac_nxt  = slot_vac_en | eff;
        hits_nxt = popcount(eff);
      end
      default: begin
        err_nxt = 1'b1;
      end
    endcase
  end

  // Control FSM with registered handshake, state and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_hits    <= '0;
      rsp_err     <= 1'b0;
      lock        <= '0;
      slot_en     <= '1;
      slot_vac_en <= '1;
      slot_kill   <= '0;
      viol_en     <= 3'b111;
    end else begin
      slot_kill <= '0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            state     <= APPLY;
          end
        end
        APPLY: begin
          lock        <= lock_nxt;
          slot_en     <= en_nxt;
          slot_vac_en <= vac_nxt;
          slot_kill   <= kill_nxt;
          viol_en     <= viol_nxt;
          rsp_hits    <= hits_nxt;
          rsp_err     <= err_nxt;
          rsp_valid   <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
